// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF_ID register: owns the PC, fetches over a req/ack
// handshake into a small FIFO. Optional JAL prediction: FETCH_STATIC_JAL_PREDICT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  input  logic        stall,
  input  logic        redirectValid,
  input  logic [31:0] redirectPC,
  output logic [31:0] instOut,
  output logic [31:0] pcOut,
  output logic        instValid
);

  localparam int          PW      = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int          CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  // Handshake: imemReq stays high with a stable imemAddr until the cycle imemAck is
  // seen; an ack outside WAIT/DISCARD is ignored, and only one request is outstanding.
  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t          state, state_nxt;
  logic [31:0]     pc, pc_nxt, seq_pc, redirect_aligned;
  logic [31:0]     q_pc   [QUEUE_DEPTH];
  logic [31:0]     q_inst [QUEUE_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            push, pop;

  assign redirect_aligned = redirectPC & ~32'h3;
  assign imemReq          = (state == WAIT);
  assign imemAddr         = pc;

`ifdef FETCH_STATIC_JAL_PREDICT_EN
  logic [31:0] jal_imm;
  assign jal_imm = {{11{imemData[31]}}, imemData[31], imemData[19:12],
                    imemData[20], imemData[30:21], 1'b0};
  assign seq_pc  = (imemData[6:0] == 7'b1101111) ? pc + jal_imm : pc + 32'd4;
`else
  assign seq_pc  = pc + 32'd4;
`endif

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (redirectValid)        pc_nxt    = redirect_aligned;
        else if (count < DEPTH_C) state_nxt = WAIT;
      end
      WAIT: begin
        if (redirectValid) begin
          pc_nxt    = redirect_aligned;
          state_nxt = imemAck ? IDLE : DISCARD;
        end else if (imemAck) begin
          push      = 1'b1;
          pc_nxt    = seq_pc;
          state_nxt = IDLE;
        end
      end
      DISCARD: begin
        if (redirectValid) pc_nxt    = redirect_aligned;
        if (imemAck)       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pop = !redirectValid && !stall && (count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= pc;
      q_inst[wr_ptr] <= imemData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirectValid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instOut   <= NOP;
      pcOut     <= RESET_PC;
      instValid <= 1'b0;
    end else if (redirectValid) begin
      instOut   <= NOP;
      instValid <= 1'b0;
    end else if (!stall) begin
      if (pop) begin
        instOut   <= q_inst[rd_ptr];
        pcOut     <= q_pc[rd_ptr];
        instValid <= 1'b1;
      end else begin
        instOut   <= NOP;
        instValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: latency-programmable memory responder plus a
// linear sequence of steps with hand-computed expectations.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instOut;
  logic [31:0] pcOut;
  logic        instValid;

  int vectors;
  int miscompares;
  int lat;
  logic spur;

  fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imemReq      (imemReq),
    .imemAddr     (imemAddr),
    .imemAck      (imemAck),
    .imemData     (imemData),
    .stall        (stall),
    .redirectValid(redirect_valid),
    .redirectPC   (redirect_pc),
    .instOut      (instOut),
    .pcOut        (pcOut),
    .instValid    (instValid)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      32'h0000_0000: word = 32'h0050_0093;
      32'h0000_0004: word = 32'h00A0_0113;
      32'h0000_0020: word = 32'h0080_006F;
      default:       word = {a[23:0], 8'h13};
    endcase
  endfunction

  // Memory responder: latches the address when a request is first seen and acks
  // lat cycles later, even if the request drops in the meantime.
  initial begin
    logic        pending;
    int          wcnt;
    logic [31:0] maddr;
    pending  = 1'b0;
    wcnt     = 0;
    maddr    = '0;
    imemAck  = 1'b0;
    imemData = '0;
    forever begin
      @(negedge clk);
      imemAck = 1'b0;
      if (!rst_n) begin
        pending = 1'b0;
      end else begin
        if (!pending && imemReq) begin
          pending = 1'b1;
          wcnt    = 0;
          maddr   = imemAddr;
        end
        if (pending) begin
          if (wcnt == lat - 1) begin
            imemAck  = 1'b1;
            imemData = word(maddr);
            pending  = 1'b0;
          end else begin
            wcnt++;
          end
        end
        if (spur) begin
          imemAck  = 1'b1;
          imemData = 32'hDEAD_BEEF;
        end
      end
    end
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    spur           = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  // Scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] inst,
                         input logic [31:0] pc);
    chk({tag, ".valid"}, {31'd0, instValid}, {31'd0, v});
    chk({tag, ".inst"}, instOut, inst);
    chk({tag, ".pc"}, pcOut, pc);
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    lat            = 1;
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    spur           = 1'b0;

    // Reset values, then 1-cycle memory
    step(2);
    chk("rst.req", {31'd0, imemReq}, 32'd0);
    chk("rst.addr", imemAddr, 32'h0);
    chk_out("rst", 1'b0, 32'h13, 32'h0);
    rst_n = 1'b1;
    step(1);
    chk("t1.req0", {31'd0, imemReq}, 32'd1);
    chk("t1.addr0", imemAddr, 32'h0);
    step(2);
    chk_out("t1.first", 1'b1, 32'h0050_0093, 32'h0);
    chk("t1.addr4", imemAddr, 32'h4);
    step(1);
    chk_out("t1.bubble", 1'b0, 32'h13, 32'h0);
    step(1);
    chk_out("t1.second", 1'b1, 32'h00A0_0113, 32'h4);
    chk("t1.addr8", imemAddr, 32'h8);
    chk("t1.req8", {31'd0, imemReq}, 32'd1);

    // Asynchronous reset with a request outstanding, then 3-cycle memory
    rst_n = 1'b0;
    #1;
    chk("arst.req", {31'd0, imemReq}, 32'd0);
    chk("arst.addr", imemAddr, 32'h0);
    chk_out("arst", 1'b0, 32'h13, 32'h0);
    lat = 3;
    do_reset();
    step(1);
    chk("t2.req_e1", {31'd0, imemReq}, 32'd1);
    step(1);
    chk("t2.addr_e2", imemAddr, 32'h0);
    chk("t2.req_e2", {31'd0, imemReq}, 32'd1);
    step(1);
    chk("t2.addr_e3", imemAddr, 32'h0);
    chk("t2.req_e3", {31'd0, imemReq}, 32'd1);
    step(1);
    chk("t2.req_e4", {31'd0, imemReq}, 32'd0);
    step(1);
    chk_out("t2.first", 1'b1, 32'h0050_0093, 32'h0);
    chk("t2.addr4", imemAddr, 32'h4);
    step(1);
    chk_out("t2.bub1", 1'b0, 32'h13, 32'h0);
    step(1);
    chk_out("t2.bub2", 1'b0, 32'h13, 32'h0);
    step(1);
    chk_out("t2.bub3", 1'b0, 32'h13, 32'h0);
    step(1);
    chk_out("t2.second", 1'b1, 32'h00A0_0113, 32'h4);
    chk("t2.addr8", imemAddr, 32'h8);

    // Stall with the queue full; a spurious ack in IDLE must not push
    lat = 1;
    do_reset();
    step(3);
    chk_out("t3.first", 1'b1, 32'h0050_0093, 32'h0);
    stall = 1'b1;
    step(4);
    chk_out("t3.hold7", 1'b1, 32'h0050_0093, 32'h0);
    chk("t3.req7", {31'd0, imemReq}, 32'd0);
    chk("t3.addr7", imemAddr, 32'hC);
    spur = 1'b1;
    step(1);
    spur = 1'b0;
    chk_out("t3.hold8", 1'b1, 32'h0050_0093, 32'h0);
    step(1);
    chk_out("t3.hold9", 1'b1, 32'h0050_0093, 32'h0);
    step(1);
    chk_out("t3.hold10", 1'b1, 32'h0050_0093, 32'h0);
    chk("t3.req10", {31'd0, imemReq}, 32'd0);
    stall = 1'b0;
    step(1);
    chk_out("t3.q0", 1'b1, 32'h00A0_0113, 32'h4);
    chk("t3.req11", {31'd0, imemReq}, 32'd0);
    step(1);
    chk_out("t3.q1", 1'b1, 32'h0000_0813, 32'h8);
    chk("t3.req12", {31'd0, imemReq}, 32'd1);
    chk("t3.addr12", imemAddr, 32'hC);
    step(1);
    chk_out("t3.bubble", 1'b0, 32'h13, 32'h8);
    step(1);
    chk_out("t3.next", 1'b1, 32'h0000_0C13, 32'hC);

    // Redirect with ack, then redirect while a request to 0x10 is outstanding
    lat = 1;
    do_reset();
    step(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    step(1);
    redirect_valid = 1'b0;
    lat            = 4;
    chk("t4.req_drop", {31'd0, imemReq}, 32'd0);
    chk("t4.addr_drop", imemAddr, 32'h10);
    chk("t4.valid_drop", {31'd0, instValid}, 32'd0);
    step(1);
    chk("t4.req10", {31'd0, imemReq}, 32'd1);
    chk("t4.addr10", imemAddr, 32'h10);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    step(1);
    redirect_valid = 1'b0;
    chk("t4.req_disc", {31'd0, imemReq}, 32'd0);
    chk("t4.addr_disc", imemAddr, 32'h100);
    chk("t4.valid_disc", {31'd0, instValid}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("t4.no_late", {31'd0, instValid}, 32'd0);
      if (i == 3) begin
        chk("t4.req100", {31'd0, imemReq}, 32'd1);
        chk("t4.addr100", imemAddr, 32'h100);
      end
    end
    step(1);
    chk_out("t4.target", 1'b1, 32'h0001_0013, 32'h100);

    // Redirect and stall together: redirect wins
    lat = 1;
    do_reset();
    step(3);
    chk_out("t5.first", 1'b1, 32'h0050_0093, 32'h0);
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step(1);
    stall          = 1'b0;
    redirect_valid = 1'b0;
    chk("t5.valid", {31'd0, instValid}, 32'd0);
    chk("t5.inst", instOut, 32'h13);
    step(1);
    chk("t5.req40", {31'd0, imemReq}, 32'd1);
    chk("t5.addr40", imemAddr, 32'h40);
    chk("t5.valid5", {31'd0, instValid}, 32'd0);
    step(1);
    chk("t5.valid6", {31'd0, instValid}, 32'd0);
    step(1);
    chk_out("t5.target", 1'b1, 32'h0000_4013, 32'h40);

    // JAL at 0x20
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    step(1);
    redirect_valid = 1'b0;
    chk("t6.req_idle", {31'd0, imemReq}, 32'd0);
    chk("t6.addr20_idle", imemAddr, 32'h20);
    step(1);
    chk("t6.req20", {31'd0, imemReq}, 32'd1);
    chk("t6.addr20", imemAddr, 32'h20);
    step(2);
    chk_out("t6.jal", 1'b1, 32'h0080_006F, 32'h20);
`ifdef FETCH_STATIC_JAL_PREDICT_EN
    chk("t6.next_addr", imemAddr, 32'h28);
`else
    chk("t6.next_addr", imemAddr, 32'h24);
`endif

    // Misaligned redirect and PC wrap at the top of the address space
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    step(1);
    redirect_valid = 1'b0;
    chk("t7.aligned", imemAddr, 32'hFFFF_FFFC);
    step(3);
    chk("t7.wrap", imemAddr, 32'h0);
    chk("t7.req", {31'd0, imemReq}, 32'd1);
    chk_out("t7.top", 1'b1, 32'hFFFF_FC13, 32'hFFFF_FFFC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF_ID pipeline register; sits directly upstream of the decoder.
- Owns the PC and issues requests to instruction memory over a req/ack handshake that tolerates variable latency.
- Buffers returned words in a small queue and presents one instruction per cycle to the decoder.
- Honours hazard stalls and branch/jump redirects from later stages.

Parameters:
- RESET_PC, 32'h0000_0000: PC after reset.
- QUEUE_DEPTH, 2: fetch queue entries (power of two, 2..8).

Ports:
- clk  input  1  pipeline clock
- rst_n  input  1  asynchronous, active-low reset
- imemReq  output  1  instruction-memory request valid
- imemAddr  output  32  word-aligned fetch address
- imemAck  input  1  response valid; imemData is meaningful this cycle
- imemData  input  32  returned instruction word
- stall  input  1  hazard stall; hold the IF_ID outputs
- redirectValid  input  1  taken branch or JAL/JALR resolved downstream
- redirectPC  input  32  redirect target
- instOut  output  32  IF_ID instruction to the decoder
- pcOut  output  32  PC of instOut
- instValid  output  1  instOut is a real instruction (0 = bubble)

Behaviour:
- Reset values (asynchronous assert, synchronous release):
  - PC = RESET_PC; imemReq = 0; imemAddr = RESET_PC.
  - instOut = 32'h0000_0013 (NOP); pcOut = RESET_PC; instValid = 0.
  - Queue empty; FSM in IDLE.
- Reset asserted mid-operation discards any outstanding request. An ack arriving after release while in IDLE is ignored.
- Request FSM (at most one request outstanding):
  - IDLE: if count + 0 < QUEUE_DEPTH, assert imemReq with imemAddr = PC and go to WAIT.
  - WAIT: imemReq stays high and imemAddr stays stable until imemAck.
    - On ack: push {PC, imemData} into the queue, set PC = PC + 4, go to IDLE. A back-to-back request may issue the next cycle.
    - Redirect in the same cycle as the ack: the data is dropped and PC = redirectPC.
  - DISCARD: entered on a redirect while in WAIT without an ack.
    - imemReq deasserts.
    - The next ack is swallowed and not pushed; then go to IDLE.
    - A further redirect while in DISCARD only updates PC.
- Queue: FIFO of {pc[31:0], inst[31:0]} with QUEUE_DEPTH entries and wrapping pointers. Never push when full; the request rule guarantees this.
- IF_ID register, updated each rising edge. Priority is redirect > stall > advance.
  - redirectValid: flush the queue; instValid = 0 and instOut = NOP next cycle.
    - PC = {redirectPC[31:2], 2'b00}; misaligned low bits are forced to 0.
    - stall is ignored that cycle.
  - stall (no redirect): instOut, pcOut and instValid hold; no pop.
  - Otherwise, queue non-empty: pop the head into instOut/pcOut and set instValid = 1.
  - Otherwise, queue empty: instOut = NOP, instValid = 0, pcOut holds.
- A pop and a push in the same cycle are legal at any occupancy. An empty queue can push and pop the same entry only on the next cycle; there is no bypass.
- Latency: with a 1-cycle memory, the first instValid appears 3 cycles after reset release (req, ack/push, pop).
- PC arithmetic is 32-bit modulo; 0xFFFF_FFFC + 4 wraps to 0.

Optional Feature:
- Macro: FETCH_STATIC_JAL_PREDICT_EN.
- When defined:
  - On a pushed word with opcode 7'b1101111 (JAL), next PC = fetched PC + sign-extended {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} instead of PC + 4.
  - instValid entries from this path carry the predicted flag internally only; the port list is unchanged.
- When undefined: PC is always sequential, and JALs are resolved only via redirectValid.

Test Plan:
- Reset release, 1-cycle-ack memory returning 0x00500093 at addr 0 and 0x00A00113 at addr 4:
  - imemAddr sequence 0, 4, 8.
  - instValid rises at cycle 3 with instOut = 0x00500093, pcOut = 0, then 0x00A00113, pcOut = 4.
- Memory with 3-cycle ack latency:
  - imemAddr held stable during WAIT.
  - instValid = 0 bubbles (instOut = 0x13) between instructions; no duplicate or lost words.
- stall held high 4 cycles with the queue full:
  - Outputs frozen, imemReq = 0, no overflow.
  - After release, the 2 queued words emerge in order.
- redirectValid with redirectPC = 0x0000_0102 while a request to 0x10 is outstanding:
  - Late ack data discarded; instValid = 0 next cycle.
  - Next imemAddr = 0x100.
- redirectValid and stall asserted together:
  - Redirect wins: queue flushed, instValid = 0, fetch resumes at the target.
- FETCH_STATIC_JAL_PREDICT_EN defined, 0x0080006F (jal x0, +8) fetched at 0x20:
  - Next imemAddr = 0x28.
  - With the macro undefined, next imemAddr = 0x24.
